// File: rtl/dma_rd_arbiter.sv
// ============================================================================
//  dma_rd_arbiter : round-robin arbiter feeding DMA read requests, with an
//                   in-order ID FIFO that routes completions back to owners.
//  Optional statistics pulses: define DMA_RD_ARBITER_STATS_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module dma_rd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 8,
  parameter int REQ_W   = 96
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_REQ-1:0]             s_req_valid,
  output logic [N_REQ-1:0]             s_req_ready,
  input  logic [N_REQ*REQ_W-1:0]       s_req_data,
  output logic                         m_req_valid,
  input  logic                         m_req_ready,
  output logic [REQ_W-1:0]             m_req_data,
  input  logic                         cmpl_valid,
  output logic [N_REQ-1:0]             s_cmpl_done,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         cmpl_err,
  output logic                         stat_req,
  output logic                         stat_done
);

  localparam int PW = $clog2(N_REQ);
  localparam int AW = $clog2(MAX_OUT);
  localparam int CW = $clog2(MAX_OUT+1);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    gnt_q, gnt_d;
  logic [REQ_W-1:0] m_req_data_q, m_req_data_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    fifo_q [MAX_OUT];
  logic [PW-1:0]    fifo_d [MAX_OUT];
  logic [N_REQ-1:0] cmpl_done_q, cmpl_done_d;
  logic             cmpl_err_q, cmpl_err_d;
  logic             init_q;

  logic             grant_found;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    cand;
  logic             issue_hs;
  logic             cmpl_pop;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(rr_ptr_q) + i) % N_REQ);
      if (!grant_found && s_req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    issue_hs = (state_q == S_ISSUE) && m_req_ready;
    cmpl_pop = cmpl_valid && (outstanding_q != '0);

    outstanding_d = outstanding_q;
    case ({issue_hs, cmpl_pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    fifo_d = fifo_q;
    if (issue_hs) begin
      fifo_d[wr_ptr_q] = gnt_q;
    end
    wr_ptr_d = wr_ptr_q + AW'(issue_hs);
    rd_ptr_d = rd_ptr_q + AW'(cmpl_pop);

    cmpl_done_d = '0;
    if (cmpl_pop) begin
      cmpl_done_d[fifo_q[rd_ptr_q]] = 1'b1;
    end
    cmpl_err_d = cmpl_err_q | (cmpl_valid && (outstanding_q == '0));

    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    m_req_data_d = m_req_data_q;
    s_req_ready  = '0;
    case (state_q)
      S_IDLE: begin
        // init_q holds off grants for the first cycle out of reset.
        if (init_q) begin
          if (outstanding_q == MAX_CNT) begin
            state_d = S_STALL;
          end else if (grant_found) begin
            s_req_ready[grant_idx] = 1'b1;
            m_req_data_d = s_req_data[int'(grant_idx)*REQ_W +: REQ_W];
            gnt_d        = grant_idx;
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (issue_hs) begin
          rr_ptr_d = (gnt_q == PW'(N_REQ-1)) ? '0 : gnt_q + 1'b1;
          state_d  = (outstanding_d == MAX_CNT) ? S_STALL : S_IDLE;
        end
      end
      S_STALL: begin
        if (outstanding_q < MAX_CNT) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      gnt_q         <= '0;
      m_req_data_q  <= '0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cmpl_done_q   <= '0;
      cmpl_err_q    <= 1'b0;
      init_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      m_req_data_q  <= m_req_data_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cmpl_done_q   <= cmpl_done_d;
      cmpl_err_q    <= cmpl_err_d;
      init_q        <= 1'b1;
    end
  end

  // ID storage needs no reset: emptiness is tracked by the pointers.
  always_ff @(posedge aclk) begin
    fifo_q <= fifo_d;
  end

  assign m_req_valid = (state_q == S_ISSUE);
  assign m_req_data  = m_req_data_q;
  assign outstanding = outstanding_q;
  assign s_cmpl_done = cmpl_done_q;
  assign cmpl_err    = cmpl_err_q;

`ifdef DMA_RD_ARBITER_STATS_EN
  logic stat_req_q;
  logic stat_done_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_req_q  <= 1'b0;
      stat_done_q <= 1'b0;
    end else begin
      stat_req_q  <= issue_hs;
      stat_done_q <= cmpl_pop;
    end
  end

  assign stat_req  = stat_req_q;
  assign stat_done = stat_done_q;
`else
  assign stat_req  = 1'b0;
  assign stat_done = 1'b0;
`endif

endmodule

`default_nettype wire
